// File: rtl/pwm_pkg.sv
// Shared constants for the PWM capture peripheral: register map, CTRL bit
// positions, capture state encoding and the duty-cycle ceiling.
package pwm_pkg;

   localparam int CNT_W_DEF = 24;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_HIGH   = 2'd1;
   localparam logic [1:0] A_PERIOD = 2'd2;
   localparam logic [1:0] A_DUTY   = 2'd3;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_VALID = 1;
   localparam int CTRL_OVF   = 2;
   localparam int CTRL_BUSY  = 3;

   localparam logic [6:0] DUTY_MAX = 7'd100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      HIGH = 2'd2,
      LOW  = 2'd3
   } state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// Register-window bus between the core load/store path and the capture block.
interface pwm_capture_if;

   logic [1:0]  A;
   logic [31:0] WD;
   logic        WE;
   logic [31:0] RD;

   modport master (output A, output WD, output WE, input RD);
   modport slave  (input A, input WD, input WE, output RD);

endinterface

// File: rtl/pwm_capture_div.sv
// Serial restoring divider for the duty cycle: one load cycle, then one
// quotient bit per cycle; the quotient is clamped to DUTY_MAX.
module pwm_capture_div
   import pwm_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [CNT_W+6:0]   num,
   input  logic [CNT_W-1:0]   den,
   output logic               busy,
   output logic               done,
   output logic [6:0]         q
);

   localparam int NUM_W = CNT_W + 7;
   localparam int IT_W  = $clog2(NUM_W + 1);
   localparam logic [IT_W-1:0] IT_LAST = IT_W'(NUM_W);

   function automatic logic [6:0] clamp_duty(input logic [NUM_W-1:0] x);
      if (x > NUM_W'(DUTY_MAX)) return DUTY_MAX;
      return x[6:0];
   endfunction

   logic             busy_q, busy_d;
   logic [IT_W-1:0]  it_q, it_d;
   logic [NUM_W-1:0] num_q, num_d, quo_q, quo_d, quo_nx;
   logic [CNT_W-1:0] den_q, den_d, rem_q, rem_d;
   logic [CNT_W:0]   rem_sh;
   logic             qbit;

   // The remainder stays below den, so the shifted value fits CNT_W+1 bits
   // and the low CNT_W bits of the subtraction are exact.
   assign rem_sh = {rem_q, quo_q[NUM_W-1]};
   assign qbit   = (rem_sh >= {1'b0, den_q});
   assign quo_nx = {quo_q[NUM_W-2:0], qbit};
   assign q      = clamp_duty(quo_nx);
   assign busy   = busy_q;

   always_comb begin
      busy_d = busy_q;
      it_d   = it_q;
      num_d  = num_q;
      den_d  = den_q;
      rem_d  = rem_q;
      quo_d  = quo_q;
      done   = 1'b0;
      if (abort) begin
         busy_d = 1'b0;
      end else if (start) begin
         busy_d = 1'b1;
         it_d   = '0;
         num_d  = num;
         den_d  = den;
      end else if (busy_q) begin
         if (it_q == '0) begin
            rem_d = '0;
            quo_d = num_q;
            it_d  = IT_W'(1);
         end else begin
            rem_d = qbit ? (rem_sh[CNT_W-1:0] - den_q) : rem_sh[CNT_W-1:0];
            quo_d = quo_nx;
            it_d  = it_q + 1'b1;
            if (it_q == IT_LAST) begin
               busy_d = 1'b0;
               done   = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         it_q   <= '0;
         num_q  <= '0;
         den_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
      end else begin
         busy_q <= busy_d;
         it_q   <= it_d;
         num_q  <= num_d;
         den_q  <= den_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
      end
   end

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: synchronizes pwm_in, measures high time and period in
// clk cycles, derives duty percent and exposes results in a 4-register window.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pwm_in,
   pwm_capture_if.slave bus
);

   localparam int NUM_W = CNT_W + 7;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, hint_q, hint_d, high_q, high_d, period_q, period_d;
   logic [6:0]       duty_q, duty_d;
   logic             en_q, en_d, valid_q, valid_d, ovf_q, ovf_d;
   logic             s, rise, fall, ctrl_wr;
   logic             div_start, div_abort, div_busy, div_done;
   logic [6:0]       div_q;
   logic [NUM_W-1:0] div_num;
   logic             unused_wd;

   assign s         = sync2_q;
   assign rise      = s & ~prev_q;
   assign fall      = ~s & prev_q;
   assign ctrl_wr   = bus.WE && (bus.A == A_CTRL);
   assign div_num   = NUM_W'(hint_q) * NUM_W'(DUTY_MAX);
   assign unused_wd = ^{bus.WD[31:3], bus.WD[1]};

   always_comb begin
      sync1_d   = pwm_in;
      sync2_d   = sync1_q;
      prev_d    = sync2_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      hint_d    = hint_q;
      high_d    = high_q;
      period_d  = period_q;
      duty_d    = duty_q;
      en_d      = en_q;
      valid_d   = valid_q;
      ovf_d     = ovf_q;
      div_start = 1'b0;
      div_abort = 1'b0;
      if (ctrl_wr) begin
         en_d = bus.WD[CTRL_EN];
         if (bus.WD[CTRL_OVF]) ovf_d = 1'b0;
      end
      if (div_done) duty_d = div_q;
      if (state_q == IDLE) begin
         cnt_d     = '0;
         valid_d   = 1'b0;
         div_abort = 1'b1;
         if (en_q) state_d = ARM;
      end else if (!en_q) begin
         state_d   = IDLE;
         cnt_d     = '0;
         valid_d   = 1'b0;
         div_abort = 1'b1;
      end else if (cnt_q == CNT_MAX) begin
         // Timeout: the ovf set is placed after the clear so set wins.
         ovf_d     = 1'b1;
         high_d    = '0;
         period_d  = '0;
         duty_d    = s ? DUTY_MAX : 7'd0;
         valid_d   = 1'b1;
         div_abort = 1'b1;
         cnt_d     = '0;
         state_d   = ARM;
      end else begin
         cnt_d = cnt_q + 1'b1;
         case (state_q)
            ARM: begin
               if (rise) begin
                  cnt_d   = CNT_ONE;
                  state_d = HIGH;
               end
            end
            HIGH: begin
               if (fall) begin
                  hint_d  = cnt_q;
                  state_d = LOW;
               end
            end
            LOW: begin
               if (rise) begin
                  high_d    = hint_q;
                  period_d  = cnt_q;
                  valid_d   = 1'b1;
                  div_start = 1'b1;
                  cnt_d     = CNT_ONE;
                  state_d   = HIGH;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         prev_q   <= 1'b0;
         state_q  <= IDLE;
         cnt_q    <= '0;
         hint_q   <= '0;
         high_q   <= '0;
         period_q <= '0;
         duty_q   <= '0;
         en_q     <= 1'b0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         prev_q   <= prev_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hint_q   <= hint_d;
         high_q   <= high_d;
         period_q <= period_d;
         duty_q   <= duty_d;
         en_q     <= en_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
      end
   end

   pwm_capture_div #(.CNT_W(CNT_W)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .start (div_start),
      .abort (div_abort),
      .num   (div_num),
      .den   (cnt_q),
      .busy  (div_busy),
      .done  (div_done),
      .q     (div_q)
   );

   always_comb begin
      bus.RD = '0;
      case (bus.A)
         A_CTRL:   bus.RD[3:0] = {div_busy, ovf_q, valid_q, en_q};
         A_HIGH:   bus.RD      = 32'(high_q);
         A_PERIOD: bus.RD      = 32'(period_q);
         A_DUTY:   bus.RD[6:0] = duty_q;
         default:  bus.RD      = '0;
      endcase
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a default-width instance driven by a PWM
// pattern generator and an 8-bit-counter instance held high for saturation.
module tb_pwm_capture;
   import pwm_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pwm_a = 1'b0;
   logic pwm_b = 1'b1;

   int  gen_hi = 30;
   int  gen_lo = 70;
   bit  gen_on = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   pwm_capture_if bus_a ();
   pwm_capture_if bus_b ();

   pwm_capture #(.CNT_W(24)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .pwm_in (pwm_a),
      .bus    (bus_a)
   );

   pwm_capture #(.CNT_W(8)) u_dut8 (
      .clk    (clk),
      .rst_n  (rst_n),
      .pwm_in (pwm_b),
      .bus    (bus_b)
   );

   always #5 clk = ~clk;

   // PWM pattern: gen_hi cycles high, gen_lo cycles low, changed on negedges.
   initial begin : gen
      forever begin
         @(negedge clk);
         if (gen_on) begin
            pwm_a = 1'b1;
            repeat (gen_hi) @(negedge clk);
            pwm_a = 1'b0;
            repeat (gen_lo - 1) @(negedge clk);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
      end
   endtask

   task automatic bus_rd(input bit b, input logic [1:0] a, output logic [31:0] d);
      if (!b) begin
         bus_a.A = a;
         #1 d = bus_a.RD;
      end else begin
         bus_b.A = a;
         #1 d = bus_b.RD;
      end
   endtask

   task automatic bus_wr(input bit b, input logic [1:0] a, input logic [31:0] wd);
      @(negedge clk);
      if (!b) begin
         bus_a.A = a; bus_a.WD = wd; bus_a.WE = 1'b1;
      end else begin
         bus_b.A = a; bus_b.WD = wd; bus_b.WE = 1'b1;
      end
      @(negedge clk);
      bus_a.WE = 1'b0;
      bus_b.WE = 1'b0;
   endtask

   task automatic wait_bit(input bit b, input int idx, input logic val, input int max_cyc,
                           input string tag);
      logic [31:0] d;
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < max_cyc && !hit; i++) begin
         @(negedge clk);
         bus_rd(b, A_CTRL, d);
         if (d[idx] === val) hit = 1'b1;
      end
      check(tag, {31'b0, hit}, 32'd1);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      logic [31:0] d;
      int n;
      bus_a.A = 2'd0; bus_a.WD = '0; bus_a.WE = 1'b0;
      bus_b.A = 2'd0; bus_b.WD = '0; bus_b.WE = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset values
      for (int a = 0; a < 4; a++) begin
         bus_rd(1'b0, a[1:0], d);
         check($sformatf("rst_rd_a%0d", a), d, 32'd0);
      end

      // Steady 30/70 PWM
      gen_hi = 30; gen_lo = 70; gen_on = 1'b1;
      bus_wr(1'b0, A_CTRL, 32'h1);
      wait_bit(1'b0, CTRL_VALID, 1'b1, 400, "t2_valid_wait");
      bus_rd(1'b0, A_HIGH, d);   check("t2_high", d, 32'd30);
      bus_rd(1'b0, A_PERIOD, d); check("t2_period", d, 32'd100);
      bus_rd(1'b0, A_CTRL, d);   check("t2_busy_start", {31'b0, d[CTRL_BUSY]}, 32'd1);
      n = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         bus_rd(1'b0, A_CTRL, d);
         if (d[CTRL_BUSY]) n++;
         else break;
      end
      check("t2_busy_cycles", 32'(n), 32'd32);
      bus_rd(1'b0, A_DUTY, d);   check("t2_duty", d, 32'd30);

      // Reset in the middle of a high phase
      @(negedge clk);
      for (int i = 0; i < 200 && pwm_a !== 1'b1; i++) @(negedge clk);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      for (int a = 0; a < 4; a++) begin
         bus_rd(1'b0, a[1:0], d);
         check($sformatf("midrst_rd_a%0d", a), d, 32'd0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (250) @(negedge clk);
      bus_rd(1'b0, A_CTRL, d);   check("midrst_ctrl_idle", d, 32'd0);
      bus_rd(1'b0, A_HIGH, d);   check("midrst_no_capture", d, 32'd0);

      // 1 high / 2 low
      gen_on = 1'b0;
      repeat (110) @(negedge clk);
      gen_hi = 1; gen_lo = 2; gen_on = 1'b1;
      bus_wr(1'b0, A_CTRL, 32'h1);
      wait_bit(1'b0, CTRL_VALID, 1'b1, 100, "t4_valid_wait");
      bus_rd(1'b0, A_HIGH, d);   check("t4_high", d, 32'd1);
      bus_rd(1'b0, A_PERIOD, d); check("t4_period", d, 32'd3);
      gen_on = 1'b0;
      wait_bit(1'b0, CTRL_BUSY, 1'b0, 100, "t4_busy_fall");
      bus_rd(1'b0, A_DUTY, d);   check("t4_duty", d, 32'd33);

      // Back-to-back period-2 input keeps restarting the divider
      repeat (10) @(negedge clk);
      gen_hi = 1; gen_lo = 1; gen_on = 1'b1;
      repeat (60) @(negedge clk);
      bus_rd(1'b0, A_CTRL, d);   check("t5_busy_running", {31'b0, d[CTRL_BUSY]}, 32'd1);
      bus_rd(1'b0, A_DUTY, d);   check("t5_duty_held", d, 32'd33);
      bus_rd(1'b0, A_HIGH, d);   check("t5_high", d, 32'd1);
      bus_rd(1'b0, A_PERIOD, d); check("t5_period", d, 32'd2);
      gen_on = 1'b0;
      wait_bit(1'b0, CTRL_BUSY, 1'b0, 100, "t5_busy_fall");
      bus_rd(1'b0, A_DUTY, d);   check("t5_duty", d, 32'd50);

      // Disable while the divider is busy
      bus_wr(1'b0, A_CTRL, 32'h0);
      repeat (5) @(negedge clk);
      gen_hi = 30; gen_lo = 70; gen_on = 1'b1;
      bus_wr(1'b0, A_CTRL, 32'h1);
      wait_bit(1'b0, CTRL_VALID, 1'b1, 400, "t6_valid_wait");
      repeat (5) @(negedge clk);
      bus_wr(1'b0, A_CTRL, 32'h0);
      @(negedge clk);
      bus_rd(1'b0, A_CTRL, d);
      check("t6_busy_off", {31'b0, d[CTRL_BUSY]}, 32'd0);
      check("t6_valid_off", {31'b0, d[CTRL_VALID]}, 32'd0);
      bus_rd(1'b0, A_DUTY, d);   check("t6_duty_kept", d, 32'd50);
      bus_rd(1'b0, A_HIGH, d);   check("t6_high_kept", d, 32'd30);
      bus_rd(1'b0, A_PERIOD, d); check("t6_period_kept", d, 32'd100);
      bus_wr(1'b0, A_HIGH, 32'hFFFF);
      bus_rd(1'b0, A_HIGH, d);   check("t6_high_ro", d, 32'd30);
      gen_on = 1'b0;

      // Constant-high input on the 8-bit-counter instance
      bus_wr(1'b1, A_CTRL, 32'h1);
      wait_bit(1'b1, CTRL_OVF, 1'b1, 600, "t7_ovf_wait");
      bus_rd(1'b1, A_CTRL, d);
      check("t7_valid", {31'b0, d[CTRL_VALID]}, 32'd1);
      check("t7_en", {31'b0, d[CTRL_EN]}, 32'd1);
      bus_rd(1'b1, A_DUTY, d);   check("t7_duty", d, 32'd100);
      bus_rd(1'b1, A_HIGH, d);   check("t7_high", d, 32'd0);
      bus_rd(1'b1, A_PERIOD, d); check("t7_period", d, 32'd0);
      bus_wr(1'b1, A_CTRL, 32'h5);
      bus_rd(1'b1, A_CTRL, d);
      check("t7_ovf_clear", {31'b0, d[CTRL_OVF]}, 32'd0);
      check("t7_en_kept", {31'b0, d[CTRL_EN]}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
